// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: strobes one active-low column per dwell, resolves one key
// per 4-column frame and debounces presses and releases over whole frames.
module keypad_matrix_scanner #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED
    } state_t;

    logic [3:0]       row_s1_q, row_s1_d;
    logic [3:0]       row_s2_q, row_s2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       col_q, col_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       hits_q, hits_d;
    logic [3:0]       first_q, first_d;
    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic             sample;
    logic             frame_end;
    logic [2:0]       col_hits;
    logic [1:0]       low_row;
    logic             low_found;
    logic [2:0]       hits_sum;
    logic [1:0]       hits_new;
    logic [3:0]       first_new;
    logic             frame_key;
    logic [CNT_W-1:0] match_next;
    logic [CNT_W-1:0] rel_next;

    always_comb begin
        row_s1_d    = row;
        row_s2_d    = row_s1_q;
        div_d       = div_q;
        col_d       = col_q;
        col_idx_d   = col_idx_q;
        hits_d      = hits_q;
        first_d     = first_q;
        state_d     = state_q;
        cand_d      = cand_q;
        match_cnt_d = match_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        sample    = (div_q == DIV_LAST);
        frame_end = sample && (col_idx_q == 2'd3);

        col_hits  = '0;
        low_row   = '0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!row_s2_q[i]) begin
                col_hits = col_hits + 3'd1;
                if (!low_found) begin
                    low_row   = 2'(i);
                    low_found = 1'b1;
                end
            end
        end

        // Hit count saturates at 2: anything above one key is a reject.
        hits_sum  = {1'b0, hits_q} + col_hits;
        hits_new  = (hits_sum > 3'd1) ? 2'd2 : hits_sum[1:0];
        first_new = (hits_q == 2'd0 && low_found) ? {low_row, col_idx_q} : first_q;
        frame_key = frame_end && (hits_new == 2'd1);

        match_next = (match_cnt_q == CNT_MAX) ? CNT_MAX : match_cnt_q + 1'b1;
        rel_next   = (rel_cnt_q == CNT_MAX) ? CNT_MAX : rel_cnt_q + 1'b1;

        if (sample) begin
            div_d     = '0;
            col_d     = {col_q[2:0], col_q[3]};
            col_idx_d = col_idx_q + 2'd1;
            if (frame_end) begin
                hits_d  = '0;
                first_d = '0;
            end else begin
                hits_d  = hits_new;
                first_d = first_new;
            end
        end else begin
            div_d = div_q + 1'b1;
        end

        if (frame_end) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_key) begin
                        cand_d      = first_new;
                        match_cnt_d = CNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            state_d     = ST_PRESSED;
                            key_code_d  = first_new;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            rel_cnt_d   = '0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_key && first_new == cand_q) begin
                        match_cnt_d = match_next;
                        if (match_next == CNT_MAX) begin
                            state_d     = ST_PRESSED;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            rel_cnt_d   = '0;
                        end
                    end else begin
                        state_d     = ST_IDLE;
                        match_cnt_d = '0;
                    end
                end
                ST_PRESSED: begin
                    if (frame_key && first_new == cand_q) begin
                        rel_cnt_d = '0;
                    end else if (rel_next == CNT_MAX) begin
                        state_d     = ST_IDLE;
                        key_held_d  = 1'b0;
                        match_cnt_d = '0;
                        rel_cnt_d   = '0;
                    end else begin
                        rel_cnt_d = rel_next;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q    <= 4'b1111;
            row_s2_q    <= 4'b1111;
            div_q       <= '0;
            col_q       <= 4'b1110;
            col_idx_q   <= '0;
            hits_q      <= '0;
            first_q     <= '0;
            state_q     <= ST_IDLE;
            cand_q      <= '0;
            match_cnt_q <= '0;
            rel_cnt_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            div_q       <= div_d;
            col_q       <= col_d;
            col_idx_q   <= col_idx_d;
            hits_q      <= hits_d;
            first_q     <= first_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            match_cnt_q <= match_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a switch-matrix model drives the rows and a
// frame-level model of the debounce rules predicts the outputs.
module tb_keypad_matrix_scanner;

    localparam int unsigned SD    = 4;
    localparam int unsigned DB    = 3;
    localparam int unsigned FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = '0;

    int errors = 0;
    int checks = 0;
    int pos    = 0;

    // reference model state (one update per frame)
    logic       m_held;
    logic       m_pulse;
    logic [3:0] m_code;
    int         m_cand;
    int         m_run;
    int         m_gap;

    // observations of the most recent frame
    int         obs_stray;
    logic       obs_held_lo;
    logic       obs_held_hi;
    logic       obs_valid;
    logic       obs_held;
    logic [3:0] obs_code;
    logic [3:0] obs_col [4];
    logic       exp_held_prev;

    always #5 clk = ~clk;

    // Closed switch (r,c) pulls row r low while column c is strobed.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    keypad_matrix_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE(DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    task automatic model_reset();
        m_held  = 1'b0;
        m_pulse = 1'b0;
        m_code  = '0;
        m_cand  = 0;
        m_run   = 0;
        m_gap   = 0;
    endtask

    task automatic model_frame(input logic [15:0] mask);
        int k;
        k = -1;
        m_pulse = 1'b0;
        if ($countones(mask) == 1)
            for (int i = 0; i < 16; i++) if (mask[i]) k = i;
        if (!m_held) begin
            if (k < 0) m_run = 0;
            else if (m_run == 0) begin m_cand = k; m_run = 1; end
            else if (k == m_cand) m_run++;
            else m_run = 0;
            if (m_run == int'(DB)) begin
                m_held  = 1'b1;
                m_pulse = 1'b1;
                m_code  = 4'(m_cand);
                m_gap   = 0;
            end
        end else begin
            if (k == m_cand) m_gap = 0;
            else m_gap++;
            if (m_gap == int'(DB)) begin
                m_held = 1'b0;
                m_run  = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        pos++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pos = 0;
        model_reset();
    endtask

    // Applies one frame of switch state and records what the DUT showed.
    task automatic run_frame(input logic [15:0] mask);
        keys          = mask;
        obs_stray     = 0;
        obs_held_lo   = 1'b1;
        obs_held_hi   = 1'b0;
        exp_held_prev = m_held;
        for (int i = 0; i < int'(FRAME); i++) begin
            tick();
            if (i % int'(SD) == 0) obs_col[i / int'(SD)] = col;
            if (i < int'(FRAME) - 1) begin
                if (key_valid) obs_stray++;
                obs_held_lo = obs_held_lo & key_held;
                obs_held_hi = obs_held_hi | key_held;
            end
        end
        obs_valid = key_valid;
        obs_held  = key_held;
        obs_code  = key_code;
        model_frame(mask);
    endtask

    task automatic test_reset();
        keys = '0;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", col); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", key_held); end
        rst = 1'b0;
        pos = 0;
        model_reset();
        repeat (4) tick();
        checks++; if (col !== 4'b1101) begin errors++; $display("FAIL col_at_4: got %b expected 1101", col); end
        repeat (12) tick();
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL col_at_16: got %b expected 1110", col); end
    endtask

    task automatic test_single_press_release();
        do_reset(2);
        for (int f = 0; f < 4; f++) begin
            run_frame(16'h0200);
            checks++; if (obs_valid !== (f == 2)) begin errors++; $display("FAIL press_valid f%0d: got %b expected %b", f, obs_valid, f == 2); end
            checks++; if (obs_stray !== 0) begin errors++; $display("FAIL press_stray f%0d: got %0d expected 0", f, obs_stray); end
            checks++; if (obs_held !== (f >= 2)) begin errors++; $display("FAIL press_held f%0d: got %b expected %b", f, obs_held, f >= 2); end
        end
        checks++; if (obs_code !== 4'd9) begin errors++; $display("FAIL press_code: got %0d expected 9", obs_code); end
        for (int f = 0; f < 3; f++) begin
            run_frame(16'h0000);
            checks++; if (obs_valid !== 1'b0 || obs_stray !== 0) begin errors++; $display("FAIL release_pulse f%0d: got valid=%b stray=%0d expected none", f, obs_valid, obs_stray); end
            checks++; if (obs_held_lo !== 1'b1) begin errors++; $display("FAIL release_held_mid f%0d: got %b expected 1", f, obs_held_lo); end
            checks++; if (obs_held !== (f < 2)) begin errors++; $display("FAIL release_held f%0d: got %b expected %b", f, obs_held, f < 2); end
            checks++; if (obs_code !== 4'd9) begin errors++; $display("FAIL release_code f%0d: got %0d expected 9", f, obs_code); end
        end
    endtask

    task automatic test_bounce();
        logic [15:0] seq [6];
        seq = '{16'h0200, 16'h0200, 16'h0000, 16'h0200, 16'h0200, 16'h0200};
        do_reset(2);
        for (int f = 0; f < 6; f++) begin
            run_frame(seq[f]);
            checks++; if (obs_valid !== (f == 5) || obs_stray !== 0) begin errors++; $display("FAIL bounce_valid f%0d: got valid=%b stray=%0d expected valid=%b stray=0", f, obs_valid, obs_stray, f == 5); end
        end
        checks++; if (obs_code !== 4'd9 || obs_held !== 1'b1) begin errors++; $display("FAIL bounce_code: got code=%0d held=%b expected code=9 held=1", obs_code, obs_held); end
    endtask

    task automatic test_ghost();
        int pulses;
        do_reset(2);
        pulses = 0;
        for (int f = 0; f < 10; f++) begin
            run_frame(16'h0021);
            pulses += obs_stray + int'(obs_valid) + int'(obs_held_hi);
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL ghost_reject: got %0d activity cycles expected 0", pulses); end
        for (int f = 0; f < 3; f++) begin
            run_frame(16'h0001);
            checks++; if (obs_valid !== (f == 2) || obs_stray !== 0) begin errors++; $display("FAIL ghost_release f%0d: got valid=%b stray=%0d expected valid=%b", f, obs_valid, obs_stray, f == 2); end
        end
        checks++; if (obs_code !== 4'd0 || obs_held !== 1'b1) begin errors++; $display("FAIL ghost_code: got code=%0d held=%b expected code=0 held=1", obs_code, obs_held); end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset(2);
        run_frame(16'h0008);
        run_frame(16'h0008);
        seen = 0;
        repeat (8) begin
            tick();
            if (key_valid) seen++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pos = 0;
        model_reset();
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_pre_pulse: got %0d expected 0", seen); end
        checks++; if (col !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'd0) begin
            errors++; $display("FAIL mid_reset_vals: got col=%b v=%b h=%b code=%0d expected 1110/0/0/0", col, key_valid, key_held, key_code);
        end
        for (int f = 0; f < 3; f++) begin
            run_frame(16'h0008);
            checks++; if (obs_valid !== (f == 2) || obs_stray !== 0) begin errors++; $display("FAIL mid_pulse f%0d: got valid=%b stray=%0d expected valid=%b", f, obs_valid, obs_stray, f == 2); end
        end
        checks++; if (obs_code !== 4'd3) begin errors++; $display("FAIL mid_code: got %0d expected 3", obs_code); end
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int unsigned r;
        do_reset(2);
        mask = '0;
        for (int f = 0; f < 60; f++) begin
            r = $urandom_range(0, 9);
            if (r == 6) mask = '0;
            else if (r == 7 || r == 9) mask = 16'h0001 << $urandom_range(0, 15);
            else if (r == 8) mask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            run_frame(mask);
            checks++; if (obs_valid !== m_pulse || obs_stray !== 0) begin errors++; $display("FAIL rand_valid f%0d: got valid=%b stray=%0d expected valid=%b stray=0", f, obs_valid, obs_stray, m_pulse); end
            checks++; if (obs_held !== m_held) begin errors++; $display("FAIL rand_held f%0d: got %b expected %b", f, obs_held, m_held); end
            checks++; if (obs_code !== m_code) begin errors++; $display("FAIL rand_code f%0d: got %0d expected %0d", f, obs_code, m_code); end
            checks++; if (obs_held_lo !== exp_held_prev || obs_held_hi !== exp_held_prev) begin errors++; $display("FAIL rand_held_mid f%0d: got lo=%b hi=%b expected %b", f, obs_held_lo, obs_held_hi, exp_held_prev); end
            for (int j = 0; j < 4; j++) begin
                checks++; if (obs_col[j] !== (4'b1111 ^ (4'b0001 << j))) begin errors++; $display("FAIL rand_col f%0d c%0d: got %b expected %b", f, j, obs_col[j], 4'b1111 ^ (4'b0001 << j)); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press_release();
        test_bounce();
        test_ghost();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

- Scans a 4×4 push-button matrix and reports one debounced key code per press.
- It reads the switch matrix in the opposite direction to the LED matrix path: it drives column strobes and samples row returns, where the LED path decodes a code onto column and line drives.
- Its `key_code`/`key_valid` outputs feed the existing display path in place of the static switch inputs.
- One column is strobed at a time. Row returns are synchronized and resolved into a single key per frame. Multi-key frames are rejected, and a key is confirmed only after a run of identical frames.

## Interface

Parameters:
- `SCAN_DIV`, default 1000: clock cycles each column is strobed (dwell); legal range ≥ 4.
- `DEBOUNCE`, default 8: consecutive identical frames required to confirm a press and to confirm a release; legal range ≥ 1.

Ports:
- `clk` (input, 1): system clock. Single clock domain.
- `rst` (input, 1): synchronous, active-high reset.
- `row` (input, 4): row returns from the matrix; active-low, externally pulled up, asynchronous to `clk`.
- `col` (output, 4): column strobes; active-low; exactly one bit is low at all times.
- `key_code` (output, 4): code of the confirmed key, equal to row_index*4 + col_index.
- `key_valid` (output, 1): one-cycle pulse when a press is confirmed.
- `key_held` (output, 1): high from press confirmation until release confirmation.

## Operation

- **Row synchronizer:** `row` passes through a 2-flop synchronizer. Both stages reset to 4'b1111 (no key).
- **Dwell counter:**
  - Counts 0..SCAN_DIV-1 and wraps.
  - When the count equals SCAN_DIV-1 (the sample cycle), the synchronized rows are sampled for the active column.
  - On that same cycle, `col` rotates to the next column: 1110 → 1101 → 1011 → 0111 → 1110.
- **Frame:**
  - A frame is 4 dwells, columns 0 to 3. Frame end is the sample cycle of column 3.
  - Within a frame, the block accumulates the number of low row bits across all columns, and the first key found, scanning lowest column first and then lowest row.
  - The frame result is one of:
    - KEY(k), if exactly one low bit was seen;
    - NONE, if zero were seen;
    - MULTI, if more than one was seen. MULTI is treated identically to NONE.
  - The accumulators clear at frame end.
- **FSM** (evaluated only at frame end; states hold between frame ends):
  - **IDLE:**
    - On KEY(k): set cand=k and match_cnt=1.
    - If DEBOUNCE==1, go to PRESSED and confirm. Otherwise go to DEBOUNCE.
    - On NONE: stay in IDLE.
  - **DEBOUNCE:**
    - On KEY(cand): increment match_cnt. When it reaches DEBOUNCE, go to PRESSED and confirm.
    - On any other result, including KEY of a different code: go to IDLE with match_cnt=0. The new code is not adopted in that same frame.
  - **PRESSED:**
    - On KEY(cand): set rel_cnt=0.
    - On any other result: increment rel_cnt. When it reaches DEBOUNCE, go to IDLE and clear `key_held`.
    - A different key pressed while the held key is released counts as release. That key then restarts from IDLE.
- **Confirm:**
  - `key_code` ← cand, `key_valid` ← 1 for exactly one cycle, `key_held` ← 1.
  - `key_code` holds its last confirmed value until the next confirm.
- **Counter widths:** match_cnt and rel_cnt are sized for DEBOUNCE and saturate. The dwell counter is sized for SCAN_DIV-1.

## Timing

- **Reset:** while `rst` is high on a rising edge, the block is set to:
  - `col`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0;
  - state IDLE, all counters and accumulators 0, synchronizer 1111.
- **Cycle numbering:** cycle 0 is the first edge with `rst` low; the dwell count is 0 on that cycle.
  - Sample cycles are cycles n·SCAN_DIV-1.
  - Frame ends are cycles 4n·SCAN_DIV-1.
- **Synchronizer latency:** 2 cycles. SCAN_DIV ≥ 4 guarantees the sampled row reflects the active column, with at least 1 cycle of settling after the strobe change.
- **Outputs:** all outputs are registered.
  - `key_valid` and `key_held` rise on the cycle after the confirming frame end.
  - `key_held` falls on the cycle after the releasing frame end.
- **Press latency:** for a key held stably from reset, `key_valid` is asserted at cycle 4·SCAN_DIV·DEBOUNCE.
- **Reset mid-operation:** `rst` asserted in any state returns the block to the reset values on the next edge. No `key_valid` pulse is emitted, and a scan that was in progress is discarded.
- **Simultaneous events:** a frame end coinciding with a dwell wrap is the normal case. Column rotation and FSM update occur on the same edge.

## Test plan

All scenarios use SCAN_DIV=4, DEBOUNCE=3 (frame = 16 cycles).

1. **Reset values:** hold `rst` 3 cycles → `col`=1110, `key_code`=0, `key_valid`=0, `key_held`=0. After release, `col` reads 1101 at cycle 4 and 1110 again at cycle 16.
2. **Single press:**
   - Stimulus: key row 2, col 1 closed from reset (`row`=1011 whenever `col`=1101, else 1111).
   - Required: `key_valid`=1 only at cycle 48, `key_code`=9, `key_held`=1 from cycle 48.
3. **Release:** in scenario 2, open the key at cycle 64 → `key_held` falls at cycle 112 (frame ends 79, 95, 111). `key_code` stays 9 and no extra `key_valid` pulse occurs.
4. **Bounce:** key 9 closed for 2 frames, open for 1, then closed steadily → no pulse during the first two frames. `key_valid` asserts 3 frames after re-closure, with `key_code`=9.
5. **Ghost rejection:** keys 0 and 5 closed together from reset → `key_valid` never asserts over 10 frames. Opening key 5 then yields `key_code`=0 with `key_valid` after 3 full frames.
6. **Reset mid-debounce:** key 3 closed, `rst` pulsed at cycle 40 → no pulse at cycle 48. Outputs return to reset values, and the pulse arrives 48 cycles after the `rst` release.
